fast_up_counter: RTL and testbench

- Up-counting counterpart of the existing fast down-counter.
- Loads a terminal value, counts up from zero on `inc` and flags when the count equals the terminal.
- On the next `inc` at terminal it auto-wraps to zero and emits a one-cycle `tick`, so the block doubles as a periodic event generator.
- Counter and comparator are split into low/high halves with registered carry/match for high Fmax at large WIDTH.

---
 rtl/fast_counter_pkg.sv | 28 ++
 rtl/carry_split_inc.sv | 132 +++++++++++++
 rtl/fast_up_counter.sv | 110 +++++++++++
 tb/tb_fast_up_counter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fast_counter_pkg.sv
// -----------------------------------------------------------------------------
// fast_counter_pkg
// Shared definitions for the fast counter family.
//
// Contents:
//   DEFAULT_WIDTH  default counter/terminal width in bits
//   half_w()       width of one counter half (the counter is split in two)
//   cnt_state_e    registered match status of the counter against its terminal
//
// Optional feature macro used by the counters in this family:
//   FAST_UP_COUNTER_VALUE_OUT_EN
// -----------------------------------------------------------------------------
package fast_counter_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Width of one half of a split counter; callers keep WIDTH even.
   function automatic int half_w(input int width);
      return width / 2;
   endfunction

   // CS_AT_TERM means the count currently held equals the terminal value.
   typedef enum logic {
      CS_COUNT   = 1'b0,
      CS_AT_TERM = 1'b1
   } cnt_state_e;

endpackage

// File: rtl/carry_split_inc.sv
// -----------------------------------------------------------------------------
// carry_split_inc
// Two-half incrementer with a registered low-half carry and per-half equality
// flags against a terminal value. It never does a full-width add or compare on
// the count: the high half only ever sees a registered carry, and the match of
// the next count is derived from half-width compares against terminal-minus-one.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (count 0, terminal 0)
//   i_load       load a new terminal from i_loadVal and clear the count
//   i_loadVal    terminal value to load (WIDTH bits)
//   i_step       advance the count by one
//   i_clear      return the count to zero, keeping the terminal
//   o_cnt        current count (only with FAST_UP_COUNTER_VALUE_OUT_EN)
//   o_matchNext  whether the count after this edge will equal the terminal
//
// Priority of the controls: rst > i_load > i_clear > i_step.
// -----------------------------------------------------------------------------
module carry_split_inc
   import fast_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_loadVal,
   input  logic             i_step,
   input  logic             i_clear,
`ifdef FAST_UP_COUNTER_VALUE_OUT_EN
   output logic [WIDTH-1:0] o_cnt,
`endif
   output logic             o_matchNext
);

   localparam int HW = half_w(WIDTH);
   localparam logic [HW-1:0] HALF_ONE   = {{(HW-1){1'b0}}, 1'b1};
   localparam logic [HW-1:0] HALF_PRE_C = {{(HW-1){1'b1}}, 1'b0};

   logic [HW-1:0] r_cntLo;
   logic [HW-1:0] r_cntHi;
   logic [HW-1:0] r_termLoM1;
   logic [HW-1:0] r_termHiM1;
   logic          r_termLoZero;
   logic          r_termHiZero;
   logic          r_loEq;
   logic          r_hiEq;
   logic          r_loCarry;

   logic [HW-1:0] w_loadLo;
   logic [HW-1:0] w_loadHi;
   logic          w_loadLoZero;
   logic          w_loadHiZero;
   logic          w_loEqStep;
   logic          w_hiEqStep;
   logic          w_loCarryStep;

   // Per-half flags describing the count one step ahead. Comparing the current
   // half against terminal-minus-one is the same as comparing the incremented
   // half against the terminal, without an adder in front of the comparator.
   // The high half only moves when the registered low carry says it will.
   always_comb begin
      w_loadLo      = i_loadVal[HW-1:0];
      w_loadHi      = i_loadVal[WIDTH-1:HW];
      w_loadLoZero  = (w_loadLo == '0);
      w_loadHiZero  = (w_loadHi == '0);
      w_loEqStep    = (r_cntLo == r_termLoM1);
      w_hiEqStep    = r_loCarry ? (r_cntHi == r_termHiM1) : r_hiEq;
      w_loCarryStep = (r_cntLo == HALF_PRE_C);
   end

   // Match status of whatever count this edge will produce, so the owner can
   // register it and have it valid in the very cycle the count lands on it.
   always_comb begin
      o_matchNext = r_loEq & r_hiEq;
      if (i_load) begin
         o_matchNext = w_loadLoZero & w_loadHiZero;
      end else if (i_clear) begin
         o_matchNext = r_termLoZero & r_termHiZero;
      end else if (i_step) begin
         o_matchNext = w_loEqStep & w_hiEqStep;
      end
   end

   // Count, terminal-derived constants and per-half flags. After reset both
   // count and terminal are zero, so the flags come up describing an equal
   // pair and terminal-minus-one is all ones. A clear reloads the equality
   // flags from the stored "terminal half is zero" bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cntLo      <= '0;
         r_cntHi      <= '0;
         r_termLoM1   <= '1;
         r_termHiM1   <= '1;
         r_termLoZero <= 1'b1;
         r_termHiZero <= 1'b1;
         r_loEq       <= 1'b1;
         r_hiEq       <= 1'b1;
         r_loCarry    <= 1'b0;
      end else if (i_load) begin
         r_cntLo      <= '0;
         r_cntHi      <= '0;
         r_termLoM1   <= w_loadLo - HALF_ONE;
         r_termHiM1   <= w_loadHi - HALF_ONE;
         r_termLoZero <= w_loadLoZero;
         r_termHiZero <= w_loadHiZero;
         r_loEq       <= w_loadLoZero;
         r_hiEq       <= w_loadHiZero;
         r_loCarry    <= 1'b0;
      end else if (i_clear) begin
         r_cntLo      <= '0;
         r_cntHi      <= '0;
         r_loEq       <= r_termLoZero;
         r_hiEq       <= r_termHiZero;
         r_loCarry    <= 1'b0;
      end else if (i_step) begin
         r_cntLo      <= r_cntLo + HALF_ONE;
         if (r_loCarry) begin
            r_cntHi   <= r_cntHi + HALF_ONE;
         end
         r_loEq       <= w_loEqStep;
         r_hiEq       <= w_hiEqStep;
         r_loCarry    <= w_loCarryStep;
      end
   end

`ifdef FAST_UP_COUNTER_VALUE_OUT_EN
   assign o_cnt = {r_cntHi, r_cntLo};
`endif

endmodule

// File: rtl/fast_up_counter.sv
// -----------------------------------------------------------------------------
// fast_up_counter
// Loadable up-counter that counts from zero to a terminal value, flags when the
// terminal is reached and, on the next advance, wraps to zero with a one-cycle
// tick. Usable as a periodic event generator with period terminal+1 advances.
// The count is split into halves with registered carry and match so the wrap
// decision never depends on a full-width compare.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides everything
//   set        load terminal from set_val and clear the count
//   set_val    terminal value (WIDTH bits)
//   inc        advance the count by one
//   q          current count (only with FAST_UP_COUNTER_VALUE_OUT_EN)
//   q_reached  registered level: count equalled terminal in the previous cycle
//   tick       registered one-cycle pulse on wrap
//
// Optional feature macro: FAST_UP_COUNTER_VALUE_OUT_EN adds the q output.
// -----------------------------------------------------------------------------
module fast_up_counter
   import fast_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [WIDTH-1:0] set_val,
   input  logic             inc,
`ifdef FAST_UP_COUNTER_VALUE_OUT_EN
   output logic [WIDTH-1:0] q,
`endif
   output logic             q_reached,
   output logic             tick
);

   cnt_state_e r_state;
   cnt_state_e w_stateNext;

   logic w_matchNext;
   logic w_atTerm;
   logic w_clear;
   logic w_step;
   logic r_qReached;
   logic r_tick;

   // The split incrementer owns the count and tells us, ahead of each edge,
   // whether the resulting count will sit on the terminal.
   carry_split_inc #(
      .WIDTH       (WIDTH)
   ) u_inc (
      .clk         (clk),
      .rst         (rst),
      .i_load      (set),
      .i_loadVal   (set_val),
      .i_step      (w_step),
      .i_clear     (w_clear),
`ifdef FAST_UP_COUNTER_VALUE_OUT_EN
      .o_cnt       (q),
`endif
      .o_matchNext (w_matchNext)
   );

   // Match status register. It starts at CS_AT_TERM because reset leaves both
   // count and terminal at zero, so an advance straight after reset wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CS_AT_TERM;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // The next status simply follows the precomputed match of the next count.
   always_comb begin
      w_stateNext = CS_COUNT;
      if (w_matchNext) begin
         w_stateNext = CS_AT_TERM;
      end
   end

   // Steering of the incrementer. A set swallows any inc in the same cycle;
   // otherwise an inc either wraps (at terminal) or steps.
   always_comb begin
      w_atTerm = (r_state == CS_AT_TERM);
      w_clear  = inc & ~set & w_atTerm;
      w_step   = inc & ~set & ~w_atTerm;
   end

   // Registered outputs. q_reached reports the match of the count held in the
   // previous cycle; tick marks the wrapping inc. Both are forced low on a
   // set so a freshly loaded terminal is only reported from the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_qReached <= 1'b0;
         r_tick     <= 1'b0;
      end else if (set) begin
         r_qReached <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_qReached <= w_atTerm;
         r_tick     <= inc & w_atTerm;
      end
   end

   assign q_reached = r_qReached;
   assign tick      = r_tick;

endmodule

// File: tb/tb_fast_up_counter.sv
// -----------------------------------------------------------------------------
// tb_fast_up_counter
// Self-checking bench for fast_up_counter at WIDTH=8. A cycle-level model of
// the counter rules runs alongside the DUT and is compared every cycle; a set
// of hand-computed expectations pins the model at key points.
// -----------------------------------------------------------------------------
module tb_fast_up_counter;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         set;
   logic [W-1:0] set_val;
   logic         inc;
   logic         q_reached;
   logic         tick;
`ifdef FAST_UP_COUNTER_VALUE_OUT_EN
   logic [W-1:0] q;
`endif

   int testsRun;
   int testsFailed;

   int   mCnt;
   int   mTerm;
   logic mQr;
   logic mTick;
   bit   mValid;

   fast_up_counter #(
      .WIDTH     (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .set       (set),
      .set_val   (set_val),
      .inc       (inc),
`ifdef FAST_UP_COUNTER_VALUE_OUT_EN
      .q         (q),
`endif
      .q_reached (q_reached),
      .tick      (tick)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it, and report it if actual differs from required.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs on the falling edge, then return just after
   // the rising edge that consumed them, with outputs settled.
   task automatic applyStimulus(input logic r, input logic s,
                                input logic [W-1:0] v, input logic i);
      @(negedge clk);
      rst     = r;
      set     = s;
      set_val = v;
      inc     = i;
      @(posedge clk);
      #2;
   endtask

   // Reference model of the counter rules, stepped on every rising edge from
   // the inputs seen at that edge, then compared with the DUT just after.
   always @(posedge clk) begin
      if (rst) begin
         mValid = 1'b1;
         mCnt   = 0;
         mTerm  = 0;
         mQr    = 1'b0;
         mTick  = 1'b0;
      end else if (set) begin
         mTerm  = int'(set_val);
         mCnt   = 0;
         mQr    = 1'b0;
         mTick  = 1'b0;
      end else begin
         mQr    = (mCnt == mTerm);
         mTick  = inc && (mCnt == mTerm);
         if (inc) begin
            mCnt = (mCnt == mTerm) ? 0 : (mCnt + 1) % (1 << W);
         end
      end
      #1;
      if (mValid) begin
         checkOutput("model q_reached", {31'd0, q_reached}, {31'd0, mQr});
         checkOutput("model tick", {31'd0, tick}, {31'd0, mTick});
`ifdef FAST_UP_COUNTER_VALUE_OUT_EN
         checkOutput("model q", {24'd0, q}, mCnt[31:0]);
`endif
      end
   end

   initial begin
      int qrHighs;
      rst     = 1'b0;
      set     = 1'b0;
      set_val = '0;
      inc     = 1'b0;
      testsRun    = 0;
      testsFailed = 0;
      mValid      = 1'b0;

      // Reset, then idle: q_reached low on the reset cycle, high afterwards.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput("reset q_reached", {31'd0, q_reached}, 32'd0);
      checkOutput("reset tick", {31'd0, tick}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
         checkOutput("idle q_reached", {31'd0, q_reached}, 32'd1);
         checkOutput("idle tick", {31'd0, tick}, 32'd0);
      end

      // Terminal 5, continuous inc: wrap on every 6th inc.
      applyStimulus(1'b0, 1'b1, 8'd5, 1'b0);
      checkOutput("set5 q_reached", {31'd0, q_reached}, 32'd0);
      for (int k = 1; k <= 13; k++) begin
         applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
         if (k == 5) checkOutput("t5 inc5 q_reached", {31'd0, q_reached}, 32'd0);
         if (k == 6) checkOutput("t5 inc6 tick", {31'd0, tick}, 32'd1);
         if (k == 6) checkOutput("t5 inc6 q_reached", {31'd0, q_reached}, 32'd1);
         if (k == 7) checkOutput("t5 inc7 tick", {31'd0, tick}, 32'd0);
         if (k == 12) checkOutput("t5 inc12 tick", {31'd0, tick}, 32'd1);
      end

      // Terminal 3, inc on alternate cycles.
      applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
         if (k == 4) checkOutput("t3 wrap tick", {31'd0, tick}, 32'd1);
         else        checkOutput("t3 step tick", {31'd0, tick}, 32'd0);
         applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
         if (k == 3) checkOutput("t3 hold q_reached", {31'd0, q_reached}, 32'd1);
         if (k == 4) checkOutput("t3 after wrap q_reached", {31'd0, q_reached}, 32'd0);
         checkOutput("t3 idle tick", {31'd0, tick}, 32'd0);
      end

      // Terminal 0: every inc wraps.
      applyStimulus(1'b0, 1'b1, 8'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
         checkOutput("t0 tick", {31'd0, tick}, 32'd1);
         checkOutput("t0 q_reached", {31'd0, q_reached}, 32'd1);
      end

      // Terminal 0x10: carry into the high half right before the terminal.
      applyStimulus(1'b0, 1'b1, 8'h10, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
         if (k == 16) checkOutput("t10 inc16 tick", {31'd0, tick}, 32'd0);
         if (k == 17) checkOutput("t10 inc17 tick", {31'd0, tick}, 32'd1);
      end

      // Full range terminal 0xFF: no match anywhere before the top.
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0);
      qrHighs = 0;
      for (int k = 1; k <= 256; k++) begin
         applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
         if (k <= 255 && q_reached) qrHighs++;
         if (k == 255) checkOutput("tFF inc255 tick", {31'd0, tick}, 32'd0);
         if (k == 256) checkOutput("tFF inc256 tick", {31'd0, tick}, 32'd1);
         if (k == 256) checkOutput("tFF inc256 q_reached", {31'd0, q_reached}, 32'd1);
      end
      checkOutput("tFF early q_reached count", qrHighs, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("tFF restart tick", {31'd0, tick}, 32'd0);

      // Mid-count set+inc, then reset with inc pending a wrap.
      applyStimulus(1'b0, 1'b1, 8'd7, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'd1, 1'b1);
      checkOutput("set+inc tick", {31'd0, tick}, 32'd0);
      checkOutput("set+inc q_reached", {31'd0, q_reached}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("t1 first inc q_reached", {31'd0, q_reached}, 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
      checkOutput("rst+inc tick", {31'd0, tick}, 32'd0);
      checkOutput("rst+inc q_reached", {31'd0, q_reached}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
      checkOutput("post-rst inc tick", {31'd0, tick}, 32'd1);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);

      #1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
